// File: rtl/log18.sv
// log18: three-stage pipelined linear-to-log2 converter (Mitchell approximation).
// Maps a (1,18) unsigned magnitude to a Q6.12 signed log2 under a single global stall.
module log18 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_data
);

    localparam logic [17:0] ZERO_CODE = 18'h20000;

    logic        advance;

    logic        s1_valid;
    logic [18:0] s1_data;
    logic        s1_zero;

    logic        s2_valid;
    logic [18:0] s2_data;
    logic        s2_zero;
    logic [4:0]  s2_pos;

    logic        s3_valid;
    logic [17:0] s3_data;

    logic [4:0]  lead_pos;
    logic [4:0]  shamt;
    logic [18:0] norm;
    logic [5:0]  exponent;
    logic [17:0] packed_result;

    // The whole pipeline moves as one; a full S3 with no taker freezes everything.
    assign advance   = !s3_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid;
    assign out_data  = s3_data;

    // Leading-one detector: the highest set bit wins because it is visited last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lead_pos = '0;
        for (int i = 0; i < 19; i++) begin
            if (s1_data[i]) begin
                lead_pos = 5'(i);
            end
        end
    end

    // Normalize so the leading one lands on bit 18; the 12 bits below it are the fraction.
    always_comb begin
        shamt         = 5'd18 - s2_pos;
        norm          = s2_data << shamt;
        exponent      = {1'b0, s2_pos} - 6'd18;
        packed_result = s2_zero ? ZERO_CODE : {exponent, norm[17:6]};
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, so nothing stale is ever visible after rst.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_zero  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_zero  <= 1'b0;
            s2_pos   <= '0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage read its predecessor's old value.
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_zero  <= (in_data == '0);
            s2_valid <= s1_valid;
            s2_data  <= s1_data;
            s2_zero  <= s1_zero;
            s2_pos   <= lead_pos;
            s3_valid <= s2_valid;
            s3_data  <= packed_result;
        end
    end

endmodule

// File: tb/tb_log18.sv
// tb_log18: randomized and directed checks of log18 against an arithmetic log/antilog model.
// A negedge monitor keeps an in-order scoreboard and checks stall stability and in_ready.
module tb_log18;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [18:0] x;
        logic [17:0] y;
    } item_t;

    item_t       sb[$];
    item_t       it;
    logic        prev_stall;
    logic [17:0] prev_data;

    log18 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int msb_pos(longint x);
        int p = 0;
        while ((x >> (p + 1)) != 0) p++;
        return p;
    endfunction

    // log2 model: exponent = p - 18, fraction = x * 2^12 / 2^p with the integer part dropped.
    function automatic logic [17:0] ref_log(logic [18:0] xin);
        longint x;
        longint frac;
        longint expo;
        int     p;
        x = longint'(xin);
        if (x == 0) return 18'h20000;
        p    = msb_pos(x);
        frac = ((x << 12) >> p) % 4096;
        expo = (longint'(p) - 18 + 64) % 64;
        return 18'(expo * 4096 + frac);
    endfunction

    function automatic logic [18:0] antilog(logic [17:0] c);
        longint m;
        int     e;
        int     p;
        if (c[17:12] == 6'b100000) return 19'h0;
        e = int'(c[17:12]);
        if (e >= 32) e = e - 64;
        p = e + 18;
        m = 4096 + longint'(c[11:0]);
        if (p >= 12) return 19'(m << (p - 12));
        return 19'(m >> (12 - p));
    endfunction

    function automatic logic [18:0] trunc12(logic [18:0] xin);
        longint x;
        int     p;
        x = longint'(xin);
        if (x == 0) return 19'h0;
        p = msb_pos(x);
        if (p <= 12) return xin;
        return 19'((x >> (p - 12)) << (p - 12));
    endfunction

    function automatic logic [18:0] rnd_nz();
        logic [18:0] x;
        x = 19'($urandom) >> $urandom_range(0, 18);
        if (x == 0) x = 19'h1;
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", sb.size(), 1);
                end else begin
                    it = sb.pop_front();
                    check("out_data", out_data, it.y);
                    check("antilog", antilog(out_data), trunc12(it.x));
                end
            end
            if (in_valid && in_ready) sb.push_back('{in_data, ref_log(in_data)});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [18:0] x, input logic [17:0] y);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 19'($urandom);
        tick();
        check("lat_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, y);
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        logic [4:0] pat;
        logic [9:0] obs;
        logic       ov[74];
        logic       acc;
        int         nv;
        int         first;
        int         last;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick();

        convert(19'h40000, 18'h00000);
        convert(19'h60000, 18'h00800);
        convert(19'h20000, 18'h3F000);
        convert(19'h00001, 18'h2E000);
        convert(19'h00003, 18'h2F800);
        convert(19'h7FFFF, 18'h00FFF);
        convert(19'h00000, 18'h20000);

        // Full-rate stream: outputs expected on exactly iterations 3..66.
        out_ready = 1'b1;
        for (int i = 0; i < 74; i++) begin
            ov[i]    = out_valid;
            in_valid = (i < 64);
            in_data  = rnd_nz();
            tick();
        end
        nv    = 0;
        first = -1;
        last  = -1;
        for (int i = 0; i < 74; i++) begin
            if (ov[i]) begin
                nv++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("rate_count", nv, 64);
        check("rate_first", first, 3);
        check("rate_last", last, 66);
        drain();

        // Backpressure: 4 stalled cycles, then out_ready toggles each cycle.
        in_valid = 1'b1;
        in_data  = rnd_nz();
        for (int c = 0; c < 60; c++) begin
            out_ready = (c < 4) ? 1'b0 : ((c < 40) ? 1'(c % 2) : 1'b1);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) in_data = rnd_nz();
        end
        drain();

        // Bubbles: in_valid 1,0,0,1,1 reappears on out_valid three cycles later.
        pat       = 5'b11001;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            obs[i]   = out_valid;
            in_valid = (i < 5) ? pat[i] : 1'b0;
            in_data  = rnd_nz();
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            check("bubble", obs[i], (i >= 3) ? pat[i-3] : 1'b0);
        end
        drain();

        // Reset with three results in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_nz();
            tick();
        end
        check("pre_rst_valid", out_valid, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("post_rst_idle", out_valid, 0);
            tick();
        end
        convert(19'h0ABCD, ref_log(19'h0ABCD));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/log18.md
# log18

Pipelined linear-to-logarithm converter: maps a 19-bit unsigned magnitude in (1,18) fixed-point format to an 18-bit signed base-2 log in Q6.12 (Mitchell approximation: leading-one position gives the integer part, the bits below it give the fraction, truncated). It is the forward-direction partner of the antilog block in the cosine datapath. Its output feeds log-domain adders, and the antilog block converts the sums back. The exponent range and zero encoding are chosen so that antilog(log18(x)) returns x with the fraction truncated to 12 bits below the leading one.

## Interface
- No parameters; widths fixed at 19 in / 18 out.
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  19  unsigned magnitude, (1,18) format, so 19'h40000 = 1.0.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  18  signed log2, Q6.12: [17:12] two's-complement exponent, [11:0] fraction.

## Operation
- p = index of the most significant 1 in in_data, range 0..18.
- exponent = p - 18, range -18..0, 6-bit two's complement: p=18 gives 6'b000000, p=0 gives 6'b101110.
- fraction[11:0] = in_data[p-1 : p-12], left-aligned. Positions below bit 0 are filled with 0. No rounding.
- out_data = {exponent, fraction}.
- Zero input: out_data = 18'h20000, i.e. exponent 6'b100000 and fraction 0. This code lies outside the antilog's valid range and decodes to 0.
- Three register stages, each carrying a valid bit:
  - S1 captures in_data and a zero flag.
  - S2 holds the leading-one position p (5 bits) plus the data.
  - S3 holds the normalized, packed out_data.
- Global stall control: advance = !out_valid || out_ready.
  - When advance is 1, every stage loads from its predecessor, and S1 loads in_data with valid = in_valid.
  - When advance is 0, all stages and their valid bits hold.
- in_ready = advance, driven combinationally.
- A transfer occurs on in_valid && in_ready (input side) and out_valid && out_ready (output side).
- Bubbles are not collapsed. An empty stage still waits for advance.
- Results leave strictly in input order. No result may be dropped or duplicated.

## Timing
- Reset: all stage valid bits = 0, out_valid = 0, out_data = 18'h0, all internal data registers = 0.
- in_ready = 1 in the first cycle after reset, because out_valid = 0.
- Latency: an input accepted at edge k gives out_valid = 1 with its result after edge k+3, provided advance stays 1. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0:
  - in_ready = 0;
  - out_data and every internal stage stay stable;
  - in_data is ignored.
- out_ready = 1 with out_valid = 0: no effect. The pipeline advances normally.
- Simultaneous input accept and output accept in the same cycle is legal and required at full rate.
- rst asserted mid-stream: on that edge all in-flight results are discarded and outputs return to their reset values. No partial result is emitted afterwards. rst has priority over advance.
- No combinational path from in_data to out_data. The only combinational path is out_ready to in_ready.

## Test plan
- Single conversions, each with out_ready held 1; every result appears 3 cycles after acceptance:
  - 19'h40000 gives 18'h00000;
  - 19'h60000 gives 18'h00800;
  - 19'h20000 gives 18'h3F000;
  - 19'h00001 gives 18'h2E000;
  - 19'h00003 gives 18'h2F800;
  - 19'h7FFFF gives 18'h00FFF.
- Zero input: 19'h00000 gives 18'h20000. Feeding that result to the antilog model must return 0.
- Full-rate stream of 64 random nonzero inputs with out_ready = 1:
  - one out_valid per cycle after the 3-cycle fill;
  - every out_data matches the reference model;
  - antilog(out_data) equals the input with the bits more than 12 positions below the leading one cleared.
- Backpressure with a continuous stream:
  - drop out_ready for 4 cycles, then toggle it every cycle;
  - in_ready mirrors advance;
  - out_data is stable during every stall;
  - sequence order is preserved and no result is lost or duplicated.
- Bubbles: in_valid pattern 1,0,0,1,1 gives out_valid pattern 1,0,0,1,1 delayed by 3 cycles.
- Reset mid-stream with 3 results in flight: out_valid = 0 on the next cycle and no stale results appear. The first post-reset input gives its correct result after 3 cycles.
